// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the MEM-stage data memory arbiter.
//   arb_state_t      : arbiter FSM states
//   DEF_DEPTH        : default data memory size in 32-bit words
//   DEF_STARVE_LIMIT : default forced-grant threshold in D_WAIT cycles
//   DEF_LEN_W        : default width of the burst length field
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      D_WAIT  = 2'd1,
      D_BURST = 2'd2,
      D_DONE  = 2'd3
   } arb_state_t;

   localparam int DEF_DEPTH        = 8;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DEF_LEN_W        = 4;

endpackage

// File: rtl/dmem_burst_agu.sv
// Burst address generator.
// Holds the latched burst base word address and length and a beat counter,
// and produces the byte address of the current beat. The word index within
// the memory wraps modulo DEPTH while the address bits above it stay fixed.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture base_word/len and clear the beat counter
//   start        : clear the beat counter (burst about to begin)
//   advance      : step to the next beat
//   base_word    : burst start address, byte address bits [31:2]
//   len          : burst length in words
//   addr         : byte address of the current beat
//   last         : current beat is the final one of the burst
module dmem_burst_agu import dmem_arb_pkg::*; #(
   parameter int DEPTH = DEF_DEPTH,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             start,
   input  logic             advance,
   input  logic [29:0]      base_word,
   input  logic [LEN_W-1:0] len,
   output logic [31:0]      addr,
   output logic             last
);

   localparam int W = $clog2(DEPTH);

   logic [29:0]      base_word_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] beat_reg;
   logic [W-1:0]     idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         base_word_reg <= '0;
         len_reg       <= '0;
         beat_reg      <= '0;
      end else if (load) begin
         base_word_reg <= base_word;
         len_reg       <= len;
         beat_reg      <= '0;
      end else if (start) begin
         beat_reg <= '0;
      end else if (advance) begin
         beat_reg <= beat_reg + 1'b1;
      end
   end

   // W-bit add truncates, giving the modulo-DEPTH wrap of the word index.
   assign idx  = base_word_reg[W-1:0] + beat_reg[W-1:0];
   assign addr = {base_word_reg[29:W], idx, 2'b00};
   assign last = (beat_reg == len_reg - 1'b1);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port MEM-stage data memory between the pipeline
// and a secondary burst requester (debug loader / test DMA). The pipeline has
// priority; a pending burst starts when the pipeline leaves the port idle or
// after STARVE_LIMIT waiting cycles, and then holds the pipeline with p_stall
// until every beat has been issued.
//   clock, reset                      : clock, synchronous active-high reset
//   p_mem_read/p_mem_write/p_addr/p_wdata : pipeline request
//   p_rdata, p_stall                  : pipeline load data and stall
//   d_req/d_write/d_base/d_len/d_wdata : burst request and write data
//   d_wdata_pop, d_rdata, d_rvalid    : burst beat handshake
//   d_done, d_err                     : burst completion / rejection pulse
//   m_read/m_write/m_addr/m_wdata/m_rdata : DataMemory port
module dmem_port_arbiter import dmem_arb_pkg::*; #(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int LEN_W        = DEF_LEN_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             p_mem_read,
   input  logic             p_mem_write,
   input  logic [31:0]      p_addr,
   input  logic [31:0]      p_wdata,
   output logic [31:0]      p_rdata,
   output logic             p_stall,
   input  logic             d_req,
   input  logic             d_write,
   input  logic [31:0]      d_base,
   input  logic [LEN_W-1:0] d_len,
   input  logic [31:0]      d_wdata,
   output logic             d_wdata_pop,
   output logic [31:0]      d_rdata,
   output logic             d_rvalid,
   output logic             d_done,
   output logic             d_err,
   output logic             m_read,
   output logic             m_write,
   output logic [31:0]      m_addr,
   output logic [31:0]      m_wdata,
   input  logic [31:0]      m_rdata
);

   localparam int WAIT_W = $clog2(STARVE_LIMIT + 2);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
   localparam logic [LEN_W:0]    DEPTH_LEN = (LEN_W + 1)'(DEPTH);

   arb_state_t        state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              write_reg, write_next;
   logic              err_reg, err_next;

   logic              agu_load, agu_start, agu_advance;
   logic [31:0]       agu_addr;
   logic              agu_last;
   logic              req_bad;

   dmem_burst_agu #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W)
   ) u_agu (
      .clock     (clock),
      .reset     (reset),
      .load      (agu_load),
      .start     (agu_start),
      .advance   (agu_advance),
      .base_word (d_base[31:2]),
      .len       (d_len),
      .addr      (agu_addr),
      .last      (agu_last)
   );

   // Rejected requests never touch memory: zero length, longer than the
   // memory, or a base that is not word aligned.
   assign req_bad = (d_len == '0) || ({1'b0, d_len} > DEPTH_LEN) ||
                    (d_base[1:0] != 2'b00);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         write_reg    <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         write_reg    <= write_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      write_next    = write_reg;
      err_next      = err_reg;
      agu_load      = 1'b0;
      agu_start     = 1'b0;
      agu_advance   = 1'b0;
      m_read        = p_mem_read;
      m_write       = p_mem_write;
      m_addr        = p_addr;
      m_wdata       = p_wdata;
      p_rdata       = m_rdata;
      p_stall       = 1'b0;
      d_rdata       = '0;
      d_rvalid      = 1'b0;
      d_wdata_pop   = 1'b0;
      d_done        = 1'b0;
      d_err         = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (d_req) begin
               agu_load   = 1'b1;
               write_next = d_write;
               err_next   = req_bad;
               if (req_bad) begin
                  state_next = D_DONE;
               end else begin
                  state_next    = D_WAIT;
                  wait_cnt_next = '0;
               end
            end
         end
         D_WAIT: begin
            if (!(p_mem_read || p_mem_write) || wait_cnt_reg == WAIT_MAX) begin
               state_next = D_BURST;
               agu_start  = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
         D_BURST: begin
            p_stall     = 1'b1;
            p_rdata     = '0;
            m_addr      = agu_addr;
            agu_advance = 1'b1;
            if (write_reg) begin
               m_read      = 1'b0;
               m_write     = 1'b1;
               m_wdata     = d_wdata;
               d_wdata_pop = 1'b1;
            end else begin
               m_read   = 1'b1;
               m_write  = 1'b0;
               m_wdata  = '0;
               d_rdata  = m_rdata;
               d_rvalid = 1'b1;
            end
            if (agu_last) begin
               state_next = D_DONE;
            end
         end
         D_DONE: begin
            d_done     = 1'b1;
            d_err      = err_reg;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Nothing may reach memory or the requester while reset is held, even
      // when the registered state still shows an interrupted burst.
      if (reset) begin
         m_read      = 1'b0;
         m_write     = 1'b0;
         p_stall     = 1'b0;
         d_rdata     = '0;
         d_rvalid    = 1'b0;
         d_wdata_pop = 1'b0;
         d_done      = 1'b0;
         d_err       = 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   localparam int DEPTH = 8;
   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        p_mem_read, p_mem_write;
   logic [31:0] p_addr, p_wdata, p_rdata;
   logic        p_stall;
   logic        d_req, d_write;
   logic [31:0] d_base;
   logic [3:0]  d_len;
   logic [31:0] d_wdata, d_rdata;
   logic        d_wdata_pop, d_rvalid, d_done, d_err;
   logic        m_read, m_write;
   logic [31:0] m_addr, m_wdata, m_rdata;

   // Behavioural DataMemory: combinational read, write on negedge.
   logic [31:0] mem [0:DEPTH-1];
   assign m_rdata = mem[m_addr[4:2]];
   always @(negedge clock) begin
      if (m_write) mem[m_addr[4:2]] <= m_wdata;
   end

   // Reference contents of the memory, maintained from the intended effects.
   logic [31:0] exp_mem [0:DEPTH-1];
   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   dmem_port_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .p_mem_read  (p_mem_read),
      .p_mem_write (p_mem_write),
      .p_addr      (p_addr),
      .p_wdata     (p_wdata),
      .p_rdata     (p_rdata),
      .p_stall     (p_stall),
      .d_req       (d_req),
      .d_write     (d_write),
      .d_base      (d_base),
      .d_len       (d_len),
      .d_wdata     (d_wdata),
      .d_wdata_pop (d_wdata_pop),
      .d_rdata     (d_rdata),
      .d_rvalid    (d_rvalid),
      .d_done      (d_done),
      .d_err       (d_err),
      .m_read      (m_read),
      .m_write     (m_write),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata)
   );

   // {p_stall, d_rvalid, d_wdata_pop, d_done, d_err, m_read, m_write}
   function automatic logic [6:0] ctrl_now();
      return {p_stall, d_rvalid, d_wdata_pop, d_done, d_err, m_read, m_write};
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic pipe_idle();
      p_mem_read  = 1'b0;
      p_mem_write = 1'b0;
      p_addr      = '0;
      p_wdata     = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p_mem_read = 1'b1; p_mem_write = 1'b1; p_addr = 32'h4; p_wdata = 32'h55;
      d_req = 1'b1; d_write = 1'b1; d_base = '0; d_len = 4'd2; d_wdata = '0;
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         #5;
         checks++;
         if (ctrl_now() !== 7'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: got ctrl=%b d_rdata=%h want ctrl=0000000 d_rdata=0",
                     i, ctrl_now(), d_rdata);
         end
         next_cycle();
      end
      reset = 1'b0; d_req = 1'b0;
      pipe_idle();
      #5;
      checks++;
      if (ctrl_now() !== 7'b0) begin
         errors++;
         $display("FAIL after_reset_idle: got ctrl=%b want 0000000", ctrl_now());
      end
      $display("reset: outputs checked during and after reset");
      next_cycle();
   endtask

   task automatic test_pipe_only();
      int op, idx;
      // Fill every word through the pipeline so the reference is defined.
      for (int i = 0; i < DEPTH; i++) begin
         p_mem_read = 1'b0; p_mem_write = 1'b1;
         p_addr = {$urandom_range(0, 255), 3'(i), 2'b00};
         p_wdata = $urandom;
         exp_mem[i] = p_wdata;
         #5;
         checks++;
         if (ctrl_now() !== 7'b0000001) begin
            errors++;
            $display("FAIL fill_ctrl word%0d: got %b want 0000001", i, ctrl_now());
         end
         next_cycle();
      end
      for (int n = 0; n < 22; n++) begin
         if (n == 0) begin op = 1; idx = 1; p_wdata = 32'h1234; end
         else if (n == 1) begin op = 2; idx = 1; end
         else begin op = $urandom_range(0, 2); idx = $urandom_range(0, DEPTH - 1); p_wdata = $urandom; end
         p_mem_read  = (op == 2);
         p_mem_write = (op == 1);
         p_addr = {$urandom_range(0, 255), 3'(idx), 2'b00};
         if (op == 1) exp_mem[idx] = p_wdata;
         #5;
         checks++;
         if (ctrl_now() !== {5'b0, op == 2, op == 1}) begin
            errors++;
            $display("FAIL pipe_ctrl op%0d: got %b want %b", n, ctrl_now(), {5'b0, op == 2, op == 1});
         end
         if (op == 2) begin
            checks++;
            if (p_rdata !== exp_mem[idx]) begin
               errors++;
               $display("FAIL pipe_load op%0d: got %h want %h", n, p_rdata, exp_mem[idx]);
            end
         end
         $display("pipe op=%0d kind=%0d word=%0d data=%h", n, op, idx, (op == 2) ? p_rdata : p_wdata);
         next_cycle();
      end
      pipe_idle();
   endtask

   task automatic check_memory(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (mem[i] !== exp_mem[i]) begin
            errors++;
            $display("FAIL %s mem[%0d]: got %h want %h", name, i, mem[i], exp_mem[i]);
         end
      end
   endtask

   // One burst request. busy[i] = pipeline uses the port in the i-th waiting
   // cycle. abort_beat >= 0 asserts reset in that beat instead of issuing it.
   task automatic run_burst(input bit wr, input logic [31:0] base, input int len,
                            input logic [4:0] busy, input int abort_beat, input string name);
      logic [31:0] data [0:DEPTH-1];
      logic [31:0] ea;
      int k, idx;
      for (int b = 0; b < DEPTH; b++) data[b] = $urandom;
      k = LIMIT;
      for (int i = 0; i <= LIMIT; i++) begin
         if (!busy[i]) begin k = i; break; end
      end
      $display("burst %s write=%0d base=%h len=%0d busy=%b wait_cycles=%0d", name, wr, base, len, busy, k + 1);

      pipe_idle();
      d_req = 1'b1; d_write = wr; d_base = base; d_len = len[3:0]; d_wdata = '0;
      #5;
      checks++;
      if (ctrl_now() !== 7'b0) begin
         errors++;
         $display("FAIL %s req_cycle: got %b want 0000000", name, ctrl_now());
      end
      next_cycle();

      for (int i = 0; i <= k; i++) begin
         p_mem_read = busy[i];
         p_mem_write = 1'b0;
         p_addr = $urandom & 32'hFFFF_FFFC;
         #5;
         checks++;
         if (ctrl_now() !== {5'b0, busy[i], 1'b0}) begin
            errors++;
            $display("FAIL %s wait%0d_ctrl: got %b want %b", name, i, ctrl_now(), {5'b0, busy[i], 1'b0});
         end
         if (busy[i]) begin
            checks++;
            if (p_rdata !== exp_mem[p_addr[4:2]]) begin
               errors++;
               $display("FAIL %s wait%0d_load: got %h want %h", name, i, p_rdata, exp_mem[p_addr[4:2]]);
            end
         end
         next_cycle();
      end

      for (int b = 0; b < len; b++) begin
         // Stalled pipeline keeps presenting a request that must be blocked.
         p_mem_read = 1'b1; p_mem_write = 1'b1;
         p_addr = $urandom & 32'hFFFF_FFFC; p_wdata = $urandom;
         d_wdata = data[b];
         idx = ((base >> 2) + b) % DEPTH;
         ea = (base & 32'hFFFF_FFE0) | 32'(idx << 2);
         if (b == abort_beat) begin
            reset = 1'b1; d_req = 1'b0;
            #5;
            checks++;
            if (ctrl_now() !== 7'b0) begin
               errors++;
               $display("FAIL %s abort_ctrl: got %b want 0000000", name, ctrl_now());
            end
            next_cycle();
            reset = 1'b0;
            pipe_idle();
            #5;
            checks++;
            if (ctrl_now() !== 7'b0) begin
               errors++;
               $display("FAIL %s post_abort_ctrl: got %b want 0000000", name, ctrl_now());
            end
            next_cycle();
            if (wr) for (int bb = 0; bb < b; bb++) exp_mem[((base >> 2) + bb) % DEPTH] = data[bb];
            check_memory(name);
            return;
         end
         #5;
         checks++;
         if (ctrl_now() !== {1'b1, !wr, wr, 2'b00, !wr, wr}) begin
            errors++;
            $display("FAIL %s beat%0d_ctrl: got %b want %b", name, b, ctrl_now(), {1'b1, !wr, wr, 2'b00, !wr, wr});
         end
         checks++;
         if (m_addr !== ea || p_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s beat%0d_addr: got addr=%h p_rdata=%h want addr=%h p_rdata=0", name, b, m_addr, p_rdata, ea);
         end
         checks++;
         if (wr ? (m_wdata !== data[b] || d_rdata !== 32'h0) : (d_rdata !== exp_mem[idx])) begin
            errors++;
            $display("FAIL %s beat%0d_data: got wdata=%h rdata=%h want %h", name, b, m_wdata, d_rdata,
                     wr ? data[b] : exp_mem[idx]);
         end
         next_cycle();
      end

      pipe_idle();
      #5;
      checks++;
      if (ctrl_now() !== 7'b0001000) begin
         errors++;
         $display("FAIL %s done_ctrl: got %b want 0001000", name, ctrl_now());
      end
      next_cycle();
      d_req = 1'b0;
      #5;
      checks++;
      if (ctrl_now() !== 7'b0) begin
         errors++;
         $display("FAIL %s after_done_ctrl: got %b want 0000000", name, ctrl_now());
      end
      next_cycle();
      if (wr) for (int b = 0; b < len; b++) exp_mem[((base >> 2) + b) % DEPTH] = data[b];
      check_memory(name);
   endtask

   task automatic test_read_burst();
      run_burst(1'b0, 32'h8, 3, 5'b00000, -1, "read_0x8_len3");
   endtask

   task automatic test_starve();
      run_burst(1'b0, 32'h0, 2, 5'b11111, -1, "starve_full");
      run_burst(1'b1, 32'h4, 3, 5'b00111, -1, "starve_partial");
   endtask

   task automatic test_write_wrap();
      run_burst(1'b1, 32'h18, 4, 5'b00000, -1, "write_wrap_0x18");
      run_burst(1'b0, 32'h18, 4, 5'b00001, -1, "readback_wrap_0x18");
   endtask

   task automatic test_error();
      logic [31:0] bases [0:2];
      int lens [0:2];
      int idx;
      bases[0] = 32'h6; lens[0] = 2;
      bases[1] = 32'h8; lens[1] = 0;
      bases[2] = 32'h0; lens[2] = 9;
      for (int c = 0; c < 3; c++) begin
         $display("reject base=%h len=%0d", bases[c], lens[c]);
         pipe_idle();
         d_req = 1'b1; d_write = $urandom_range(0, 1); d_base = bases[c]; d_len = lens[c][3:0];
         #5;
         checks++;
         if (ctrl_now() !== 7'b0) begin
            errors++;
            $display("FAIL reject%0d_req: got %b want 0000000", c, ctrl_now());
         end
         next_cycle();
         idx = $urandom_range(0, DEPTH - 1);
         p_mem_write = 1'b1; p_addr = {24'h0, 3'(idx), 2'b00} | 32'h100; p_wdata = $urandom;
         exp_mem[idx] = p_wdata;
         #5;
         checks++;
         if (ctrl_now() !== 7'b0001101 || m_addr !== p_addr || m_wdata !== p_wdata) begin
            errors++;
            $display("FAIL reject%0d_done: got ctrl=%b addr=%h want ctrl=0001101 addr=%h", c, ctrl_now(), m_addr, p_addr);
         end
         next_cycle();
         d_req = 1'b0;
         pipe_idle();
         #5;
         checks++;
         if (ctrl_now() !== 7'b0) begin
            errors++;
            $display("FAIL reject%0d_after: got %b want 0000000", c, ctrl_now());
         end
         next_cycle();
      end
      check_memory("reject");
   endtask

   task automatic test_reset_mid();
      run_burst(1'b1, 32'h0, 5, 5'b00000, 2, "abort_len5");
   endtask

   task automatic test_random();
      logic [31:0] base;
      for (int n = 0; n < 12; n++) begin
         base = {$urandom, 2'b00};
         run_burst($urandom_range(0, 1) == 1, base, $urandom_range(1, DEPTH),
                   5'($urandom_range(0, 31)), -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_read_burst();
      test_starve();
      test_write_wrap();
      test_error();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
